// File: rtl/ccc_mon_pkg.sv
// Shared types and defaults for the CCC lock monitor: FSM state encoding,
// default dwell/timeout lengths and a constant clog2 used to size the counter.
package ccc_mon_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StDwell    = 3'd2,
        StLocked   = 3'd3,
        StFault    = 3'd4
    } mon_state_e;

    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter must hold max(STABLE, TIMEOUT) itself, hence the +1.
    localparam int unsigned DEF_CNT_W = clog2(((DEF_TIMEOUT_CYCLES > DEF_STABLE_CYCLES) ?
                                               DEF_TIMEOUT_CYCLES : DEF_STABLE_CYCLES) + 1);

endpackage

// File: rtl/ccc_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the local clock
// domain; all stages clear on reset.
module ccc_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_monitor.sv
// Qualifies the synchronised CCC lock, releases the fabric reset after a stable
// dwell, counts lock losses and flags timeouts. `LOCK_MON_IRQ_EN adds an IRQ pulse.
module ccc_lock_monitor
    import ccc_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned LOSS_W         = 8
) (
    input  logic              FAB_CLK,
    input  logic              M2F_RESET_N,
    input  logic              LOCK_ASYNC,
    input  logic              ENABLE,
    input  logic              CLR_STATUS,
    output logic              LOCK_OK,
    output logic              SYS_RESET_N,
    output logic [LOSS_W-1:0] LOSS_COUNT,
    output logic              TIMEOUT,
    output logic [2:0]        STATE
`ifdef LOCK_MON_IRQ_EN
    ,
    output logic              IRQ
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // The lk=1 cycle seen in WAIT_LOCK/FAULT counts toward the dwell, so DWELL
    // itself needs only STABLE_CYCLES-1 high cycles (STABLE_CYCLES >= 2).
    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(STABLE_CYCLES - 2);

    logic              lk;
    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              timeout_q, timeout_d;
    logic              lock_ok_q, sys_rst_n_q;
    logic              loss_evt, loss_inc, timeout_set;

    ccc_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (FAB_CLK),
        .rst_n (M2F_RESET_N),
        .d     (LOCK_ASYNC),
        .q     (lk)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loss_evt    = 1'b0;
        timeout_set = 1'b0;
        if (!ENABLE) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
                StWaitLock: begin
                    if (lk) begin
                        state_d = StDwell;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = StFault;
                        cnt_d       = '0;
                        timeout_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDwell: begin
                    if (!lk) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == DWELL_LAST) begin
                        state_d = StLocked;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StLocked: begin
                    if (!lk) begin
                        state_d  = StWaitLock;
                        cnt_d    = '0;
                        loss_evt = 1'b1;
                    end
                end
                StFault: begin
                    if (lk) begin
                        state_d = StDwell;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        // Clear beats a coincident loss; a coincident timeout beats the clear.
        loss_inc  = loss_evt & ~CLR_STATUS & (loss_q != '1);
        loss_d    = CLR_STATUS ? '0 : (loss_inc ? loss_q + LOSS_W'(1) : loss_q);
        timeout_d = timeout_set | (timeout_q & ~CLR_STATUS);
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            loss_q      <= '0;
            timeout_q   <= 1'b0;
            lock_ok_q   <= 1'b0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            timeout_q   <= timeout_d;
            lock_ok_q   <= (state_d == StLocked);
            sys_rst_n_q <= (state_d == StLocked);
        end
    end

    assign LOCK_OK     = lock_ok_q;
    assign SYS_RESET_N = sys_rst_n_q;
    assign LOSS_COUNT  = loss_q;
    assign TIMEOUT     = timeout_q;
    assign STATE       = state_q;

`ifdef LOCK_MON_IRQ_EN
    logic irq_q;

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= loss_inc | (timeout_set & ~timeout_q);
        end
    end

    assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_ccc_lock_monitor.sv
// Scoreboard bench for ccc_lock_monitor: directed scenarios then random lock
// traffic, checked cycle by cycle against a run-length reference model.
module tb_ccc_lock_monitor;

    localparam int unsigned SYNC     = 2;
    localparam int unsigned STABLE   = 16;
    localparam int unsigned TMO      = 64;
    localparam int unsigned LOSS_W   = 2;
    localparam int          LOSS_MAX = (1 << LOSS_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              lock_async = 1'b0;
    logic              enable = 1'b0;
    logic              clr = 1'b0;
    logic              lock_ok, sys_rst_n, timeout;
    logic [LOSS_W-1:0] loss;
    logic [2:0]        state;

    always #5 clk = ~clk;

    ccc_lock_monitor #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8),
        .LOSS_W         (LOSS_W)
    ) dut (
        .FAB_CLK     (clk),
        .M2F_RESET_N (rst_n),
        .LOCK_ASYNC  (lock_async),
        .ENABLE      (enable),
        .CLR_STATUS  (clr),
        .LOCK_OK     (lock_ok),
        .SYS_RESET_N (sys_rst_n),
        .LOSS_COUNT  (loss),
        .TIMEOUT     (timeout),
        .STATE       (state)
    );

    typedef struct packed {
        logic              lock_ok;
        logic              sys_rst_n;
        logic [LOSS_W-1:0] loss;
        logic              tmo;
        logic [2:0]        state;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode 0 idle, 1 waiting, 2 qualifying, 3 locked, 4 fault.
    int m_mode, m_hi, m_wait, m_loss;
    bit m_tmo;
    bit m_hist[SYNC];
    bit clr_on_loss = 1'b0;
    bit clr_on_tmo  = 1'b0;

    function automatic void model_reset();
        m_mode = 0;
        m_hi   = 0;
        m_wait = 0;
        m_loss = 0;
        m_tmo  = 1'b0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.lock_ok   = (m_mode == 3);
        o.sys_rst_n = (m_mode == 3);
        o.loss      = LOSS_W'(m_loss);
        o.tmo       = m_tmo;
        o.state     = 3'(m_mode);
        return o;
    endfunction

    function automatic bit will_loss(bit en);
        return en && m_mode == 3 && !m_hist[SYNC-1];
    endfunction

    function automatic bit will_tmo(bit en);
        return en && m_mode == 1 && !m_hist[SYNC-1] && (m_wait + 1 == TMO);
    endfunction

    function automatic void model_edge(bit en, bit c, bit la);
        bit lk;
        bit loss_evt;
        bit tmo_set;
        lk = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = la;
        loss_evt = 1'b0;
        tmo_set  = 1'b0;
        if (!en) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_wait = 0; end
                1: begin
                    if (lk) begin
                        m_mode = 2; m_hi = 1;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_mode = 4; tmo_set = 1'b1; end
                    end
                end
                2: begin
                    if (lk) begin
                        m_hi++;
                        if (m_hi == STABLE) m_mode = 3;
                    end else begin
                        m_mode = 1; m_wait = 0;
                    end
                end
                3: if (!lk) begin m_mode = 1; m_wait = 0; loss_evt = 1'b1; end
                4: if (lk) begin m_mode = 2; m_hi = 1; end
                default: m_mode = 0;
            endcase
        end
        if (c) m_loss = 0;
        else if (loss_evt && m_loss < LOSS_MAX) m_loss++;
        if (tmo_set) m_tmo = 1'b1;
        else if (c) m_tmo = 1'b0;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.lock_ok   = lock_ok;
        o.sys_rst_n = sys_rst_n;
        o.loss      = loss;
        o.tmo       = timeout;
        o.state     = state;
        return o;
    endfunction

    function automatic void check(string name, obs_t got, obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got lock_ok=%b sys_rst_n=%b loss=%0d tmo=%b state=%0d want lock_ok=%b sys_rst_n=%b loss=%0d tmo=%b state=%0d",
                     name, $time, got.lock_ok, got.sys_rst_n, got.loss, got.tmo, got.state,
                     want.lock_ok, want.sys_rst_n, want.loss, want.tmo, want.state);
        end
    endfunction

    // One clock of stimulus; the model's view after the coming edge is queued.
    task automatic step(input bit en, input bit la, input bit c_in, input bit rst_in = 1'b1);
        bit c;
        @(negedge clk);
        c = c_in | (clr_on_loss && will_loss(en)) | (clr_on_tmo && will_tmo(en));
        enable     = en;
        lock_async = la;
        clr        = c;
        if (!rst_in) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check("async_reset", dut_obs(), model_obs());
        end else begin
            rst_n = 1'b1;
            model_edge(en, c, la);
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic hold(input bit en, input bit la, input int n);
        for (int i = 0; i < n; i++) step(en, la, 1'b0);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_obs(), e);
            end
        end
    end

    initial begin : stimulus
        bit la_r;
        int len;
        bit en_r;
        model_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

        // First lock with a glitch during the dwell.
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 8);
        hold(1'b1, 1'b0, 3);
        hold(1'b1, 1'b1, 25);

        // Five losses saturate the counter, then clear coincident with a sixth.
        repeat (5) begin
            hold(1'b1, 1'b0, 5);
            hold(1'b1, 1'b1, 25);
        end
        clr_on_loss = 1'b1;
        hold(1'b1, 1'b0, 5);
        clr_on_loss = 1'b0;
        hold(1'b1, 1'b1, 25);

        // Enable drop while locked, then relock.
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 25);

        // Timeout with a coincident clear, late lock, then explicit clear.
        hold(1'b1, 1'b0, 5);
        clr_on_tmo = 1'b1;
        hold(1'b1, 1'b0, 70);
        clr_on_tmo = 1'b0;
        hold(1'b1, 1'b1, 25);
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 3);

        // Reset asserted mid-dwell.
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b1, 8);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b1, 25);

        // Random lock traffic with occasional disable, clear and reset.
        la_r = 1'b1;
        for (int seg = 0; seg < 120; seg++) begin
            la_r = ~la_r;
            if (la_r) len = $urandom_range(1, 40);
            else if ($urandom_range(0, 5) == 0) len = $urandom_range(60, 90);
            else len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                en_r = ($urandom_range(0, 60) != 0);
                step(en_r, la_r, ($urandom_range(0, 40) == 0), ($urandom_range(0, 400) != 0));
            end
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
